// File: rtl/booth_seq_multiplier.sv
// ---------------------------------------------------------------------------
// booth_seq_multiplier
//
// Sequential radix-2 Booth multiplier for signed (two's-complement) operands.
// It sits beside the ALU as a multi-cycle multiply unit with a start/done
// handshake. Each cycle the datapath evaluates an adder (A+M), a subtractor
// (A-M) and an arithmetic right shift over {A,Q,Q_1}. The result is ready
// WIDTH cycles after the load edge.
//
// Parameters
//   WIDTH  operand width in bits; the product is 2*WIDTH bits wide.
//
// Ports
//   clk    in   clock; all state updates happen on the rising edge
//   rst    in   synchronous, active-high reset; aborts a multiply in flight
//   start  in   begin a multiply; sampled only while idle
//   M      in   [WIDTH-1:0]    multiplicand, signed
//   Q      in   [WIDTH-1:0]    multiplier, signed
//   busy   out  high while a multiply is in progress
//   done   out  one-cycle pulse on the edge that updates out
//   out    out  [2*WIDTH-1:0]  signed product, held until the next completion
//
// Optional build macro
//   BOOTH_TRACE_EN  when defined, each iteration logs A, Q_reg, Q_1 and count
//                   to the simulation log, and completion logs the product.
//                   When undefined, no display code is compiled and the RTL
//                   is purely synthesizable. Behaviour is identical in both
//                   builds.
// ---------------------------------------------------------------------------
module booth_seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     M,
  input  logic [WIDTH-1:0]     Q,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   out
);

  // count must be able to hold the value WIDTH, which it reaches after the
  // final iteration.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t state_q, state_d;

  // The accumulator carries one extra bit. Without it, subtracting
  // M = -2^(WIDTH-1) would overflow: the result would wrap and the sign of
  // the partial product would be lost.
  logic [WIDTH:0]       a_q;
  logic [WIDTH-1:0]     q_reg_q;
  logic                 q_1_q;
  logic [WIDTH-1:0]     m_reg_q;
  logic [CW-1:0]        count_q;
  logic                 done_q;
  logic [2*WIDTH-1:0]   out_q;

  // FSM decode outputs
  logic                 load;
  logic                 finish;

  // Datapath signals
  logic [WIDTH:0]       m_ext;
  logic [WIDTH:0]       a_add;
  logic [WIDTH:0]       a_sub;
  logic [WIDTH:0]       a_sel;
  logic [WIDTH:0]       a_shr;
  logic [WIDTH-1:0]     q_shr;

  // -------------------------------------------------------------------------
  // Control FSM: the state register
  // -------------------------------------------------------------------------
  // NOTE: Sequential state uses non-blocking (<=) assignments. All registers
  // then update together from values sampled before the edge, and the result
  // does not depend on the order in which the always blocks run.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Control FSM: next state and strobes.
  // The FSM is back in S_IDLE during the cycle done is high, so a start in
  // that cycle is accepted and multiplies can run back to back.
  // NOTE: Every signal assigned here gets a default value first. A path that
  // leaves a signal unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // A start seen in this state is ignored.
        if (count_q == LAST_ITER) begin
          finish  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: adder, subtractor, Booth select and arithmetic right shift.
  // All of it is combinational and is evaluated once per cycle.
  // -------------------------------------------------------------------------
  assign m_ext = {m_reg_q[WIDTH-1], m_reg_q};
  assign a_add = a_q + m_ext;
  assign a_sub = a_q - m_ext;

  always_comb begin
    a_sel = a_q;
    unique case ({q_reg_q[0], q_1_q})
      2'b10:   a_sel = a_sub;   // start of a run of 1s
      2'b01:   a_sel = a_add;   // end of a run of 1s
      default: a_sel = a_q;     // 00 / 11: inside a run, no partial product
    endcase
  end

  // Shift {A,Q_reg,Q_1} right by one. A keeps its sign bit, A[0] moves into
  // the MSB of Q_reg, and Q_reg[0] becomes the new Q_1.
  assign a_shr = {a_sel[WIDTH], a_sel[WIDTH:1]};
  assign q_shr = {a_sel[0], q_reg_q[WIDTH-1:1]};

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      q_reg_q <= '0;
      q_1_q   <= 1'b0;
      m_reg_q <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      done_q <= finish;
      if (load) begin
        m_reg_q <= M;
        q_reg_q <= Q;
        a_q     <= '0;
        q_1_q   <= 1'b0;
        count_q <= '0;
      end else if (state_q == S_RUN) begin
        a_q     <= a_shr;
        q_reg_q <= q_shr;
        q_1_q   <= q_reg_q[0];
        count_q <= count_q + CW'(1);
        // The product is taken from the post-shift values of the last
        // iteration. The top bit of A is only a guard bit and is dropped.
        if (finish) begin
          out_q <= {a_shr[WIDTH-1:0], q_shr};
        end
      end
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = done_q;
  assign out  = out_q;

`ifdef BOOTH_TRACE_EN
  // -------------------------------------------------------------------------
  // Simulation trace. Prints the post-iteration state so that the log lines
  // up with the register values seen after each edge.
  // -------------------------------------------------------------------------
  always @(posedge clk) begin
    if (!rst && state_q == S_RUN) begin
      $display("booth: A=%b Q=%b Q_1=%b count=%0d",
               a_shr, q_shr, q_reg_q[0], count_q + CW'(1));
      if (finish) begin
        $display("booth: product=%0d (0x%h)",
                 $signed({a_shr[WIDTH-1:0], q_shr}),
                 {a_shr[WIDTH-1:0], q_shr});
      end
    end
  end
`else
  // Trace disabled: nothing is compiled here.
`endif

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// ---------------------------------------------------------------------------
// tb_booth_seq_multiplier
//
// Directed testbench for booth_seq_multiplier (WIDTH = 8). Every expected
// product is a hand-computed constant. The bench also checks latency, busy
// duration, the one-cycle done pulse, that a start while busy is ignored,
// back-to-back operation, and that a reset mid-multiply aborts it cleanly.
// ---------------------------------------------------------------------------
module tb_booth_seq_multiplier;

  localparam int WIDTH = 8;
  localparam int TIMEOUT = 40;

  logic               clk;
  logic               rst;
  logic               start;
  logic [WIDTH-1:0]   m_in;
  logic [WIDTH-1:0]   q_in;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] out;

  int vectors;
  int miscompares;

  booth_seq_multiplier #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .M     (m_in),
    .Q     (q_in),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Call this #1 after a rising edge. It presents the operands with start
  // high, lets the next edge load them, then drops start.
  task automatic start_op(input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] q);
    m_in  = m;
    q_in  = q;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Call this #1 after the load edge. It waits for done, counting edges and
  // busy cycles, and returns #1 after the edge that raised done. When
  // inj_at > 0, it pulses start with other operands after iteration inj_at;
  // that start must be ignored.
  task automatic wait_done(input string tag, input logic [15:0] exp,
                           input int inj_at);
    int n;
    int busy_cycles;
    n = 0;
    busy_cycles = busy ? 1 : 0;
    while (n < TIMEOUT) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      n++;
      if (done) break;
      if (busy) busy_cycles++;
      if (n == inj_at) begin
        m_in  = 8'h0B;
        q_in  = 8'h0B;
        start = 1'b1;
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, n, WIDTH);
    check({tag, "_busy_cycles"}, busy_cycles, WIDTH);
    check({tag, "_busy_at_done"}, busy, 1'b0);
    check({tag, "_out"}, out, exp);
  endtask

  // One cycle after done: the pulse has ended, the unit is idle and out is held.
  task automatic check_idle(input string tag, input logic [15:0] exp);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_idle"}, busy, 1'b0);
    check({tag, "_out_held"}, out, exp);
  endtask

  task automatic run_mul(input string tag, input logic [WIDTH-1:0] m,
                         input logic [WIDTH-1:0] q, input logic [15:0] exp);
    start_op(m, q);
    wait_done(tag, exp, 0);
    check_idle(tag, exp);
  endtask

  initial begin
    int done_seen;
    vectors     = 0;
    miscompares = 0;
    rst   = 1'b1;
    start = 1'b0;
    m_in  = '0;
    q_in  = '0;

    // Reset for two cycles, then release.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_out", out, 16'h0000);
    check("reset_done", done, 1'b0);
    check("reset_busy", busy, 1'b0);

    // Basic products and sign cases.
    run_mul("3x4",       8'h03, 8'h04, 16'h000C);
    run_mul("m3x5",      8'hFD, 8'h05, 16'hFFF1);
    run_mul("5xm3",      8'h05, 8'hFD, 16'hFFF1);
    run_mul("m128xm128", 8'h80, 8'h80, 16'h4000);
    run_mul("127xm128",  8'h7F, 8'h80, 16'hC080);
    run_mul("m128x127",  8'h80, 8'h7F, 16'hC080);
    run_mul("0x5A",      8'h00, 8'h5A, 16'h0000);
    run_mul("127x127",   8'h7F, 8'h7F, 16'h3F01);
    run_mul("m1xm1",     8'hFF, 8'hFF, 16'h0001);
    run_mul("m1xm128",   8'hFF, 8'h80, 16'h0080);

    // A start pulsed mid-operation with other operands is ignored.
    start_op(8'hF9, 8'h09);               // -7 * 9 = -63
    wait_done("restart_ignored", 16'hFFC1, 3);
    check_idle("restart_ignored", 16'hFFC1);

    // Back to back: a new start is presented while done is high.
    start_op(8'h06, 8'h07);               // 42
    wait_done("b2b_first", 16'h002A, 0);
    start_op(8'hFE, 8'h09);               // -2 * 9 = -18
    wait_done("b2b_second", 16'hFFEE, 0);
    check_idle("b2b_second", 16'hFFEE);

    // Reset on the fourth iteration edge aborts the multiply without a done.
    start_op(8'h0A, 8'h0A);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_out", out, 16'h0000);
    check("abort_done", done, 1'b0);
    done_seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done || busy) done_seen++;
    end
    check("abort_no_done", done_seen, 0);

    // A fresh multiply after the abort.
    run_mul("7x6", 8'h07, 8'h06, 16'h002A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
